// File: rtl/addr_trace_fifo.sv
// addr_trace_fifo: first-word fall-through trace FIFO with drop counting and high-water tracking
module addr_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [CNT_W-1:0]  hwm,
  input  logic              clear_stats
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CNT_W-1:0]  r_level, r_hwm;
  logic              r_ovf;
  logic [15:0]       r_drop;
  logic              w_pop, w_push, w_drop;
  logic [CNT_W-1:0]  w_level_nxt;
  assign empty    = r_level == '0;
  assign full     = r_level == CNT_W'(DEPTH);
  assign rd_valid = !empty;
  assign level    = r_level;
  assign hwm      = r_hwm;
  assign overflow = r_ovf;
  assign drop_cnt = r_drop;
  assign rd_data  = r_mem[r_rp];
  assign w_pop    = rd_valid && rd_ready;
  // a pop in the same cycle frees the slot, so a push at full still completes
  assign w_push   = wr_en && (!full || w_pop);
  assign w_drop   = wr_en && full && !w_pop;
  assign w_level_nxt = r_level + CNT_W'(w_push) - CNT_W'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_hwm   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
      r_level <= w_level_nxt;
      // clear wins over a coincident drop
      r_hwm   <= (clear_stats || w_level_nxt > r_hwm) ? w_level_nxt : r_hwm;
      r_ovf   <= clear_stats ? 1'b0 : (r_ovf || w_drop);
      r_drop  <= clear_stats ? '0 : (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
    end
  end
endmodule
